// File: rtl/nibble_serial_adder.sv
// Nibble-serial wide adder/subtractor: operands are captured through a valid/ready
// handshake and summed one 4-bit slice per clock through a single ripple-carry stage.

module nibble_adder4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_c3,
    output logic       o_cout
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < 4; g++) begin : g_bit
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (i_a[g] & w_c[g]) | (i_b[g] & w_c[g]);
    end

    // Carry into bit 3 is exported so the MSB slice can report signed overflow.
    assign o_c3   = w_c[3];
    assign o_cout = w_c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_cout;
    logic          r_ovf;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [3:0]    w_a_nib;
    logic [3:0]    w_b_nib;
    logic [3:0]    w_nsum;
    logic          w_nc3;
    logic          w_ncout;
    logic          w_accept;
    logic          w_last;

    assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;
    assign w_last   = (r_idx == IW'(NIBBLES - 1));

    // Select the operand slices addressed by the current index.
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end else begin
                w_a_nib = w_a_nib;
                w_b_nib = w_b_nib;
            end
        end
    end

    nibble_adder4 u_add (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_nsum),
        .o_c3   (w_nc3),
        .o_cout (w_ncout)
    );

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_ADD;  else w_next = S_IDLE;
            S_ADD:   if (w_last)    w_next = S_DONE; else w_next = S_ADD;
            S_DONE:  if (out_ready) w_next = S_IDLE; else w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state so
    // in_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_DONE);
        end
    end

    // Operand capture and slice-by-slice accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                    end
                end
                S_ADD: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_sum[4*i +: 4] <= w_nsum;
                        end
                    end
                    r_carry <= w_ncout;
                    if (w_last) begin
                        r_cout <= w_ncout;
                        r_ovf  <= w_nc3 ^ w_ncout;
                    end else begin
                        r_idx  <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a signed/unsigned
// arithmetic reference model checked on every cycle a result is presented.

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          seen;
    } exp_t;
    exp_t q[$];

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    endtask

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_v,
                                   input logic tc, input logic ts);
        exp_t e;
        int   sa, sb, res;
        int   ua, ub;
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        ua = int'({16'd0, ta});
        ub = int'({16'd0, tb_v});
        res = ts ? (sa - sb) : (sa + sb + int'(tc));
        e.s = res[15:0];
        e.o = (res > 32767) || (res < -32768);
        e.c = ts ? (ua >= ub) : ((ua + ub + int'(tc)) > 65535);
        e.acc = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    // Reference scoreboard: push on accept, pop on result transfer.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e = model(a, b, cin, sub);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    // Compare every presented result cycle against the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                chk("model_sum",  {16'd0, sum}, {16'd0, q[0].s});
                chk("model_cout", {31'd0, cout}, {31'd0, q[0].c});
                chk("model_ovf",  {31'd0, ovf},  {31'd0, q[0].o});
                chk("ready_in_done", {31'd0, in_ready}, 32'd0);
                if (!q[0].seen) begin
                    chk("latency", cyc - q[0].acc, 32'd4);
                    q[0].seen = 1'b1;
                end
            end
        end
    end

    // Drive operands from a negedge and return at the negedge after the accept edge.
    task automatic start(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts);
        int k;
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic finish(input string nm, input logic [15:0] es, input logic ec, input logic eo);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_sum"},  {16'd0, sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic op(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tc, input logic ts,
                      input logic [15:0] es, input logic ec, input logic eo);
        start(ta, tb_v, tc, ts);
        in_valid = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc; sub = ~ts;
        finish(nm, es, ec, eo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_cout_ovf",  {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        op("add_basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("add_cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("add_povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("add_novf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // out_ready held high throughout: no effect until a result is present.
        out_ready = 1'b1;
        start(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        in_valid = 1'b0;
        begin
            int k;
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("early_ready_sum", {16'd0, sum}, 32'h1000);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("early_ready_drop", {31'd0, out_valid}, 32'd0);

        // Backpressure with new operands pending on in_valid.
        start(16'h0102, 16'h0304, 1'b0, 1'b0);
        a = 16'h1000; b = 16'h0234;
        begin
            int k;
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid",    {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready},  32'd0);
            chk("bp_sum",      {16'd0, sum},       32'h0406);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, in_ready},  32'd1);
        chk("bp_held_sum",   {16'd0, sum},       32'h0406);
        @(negedge clk);
        chk("bp_next_accept", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        finish("bp_pending", 16'h1234, 1'b0, 1'b0);

        // Asynchronous reset in the middle of ADD (idx=2).
        start(16'hAAAA, 16'h1111, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sum",       {16'd0, sum},       32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_release_ready", {31'd0, in_ready},  32'd1);
        chk("arst_no_result",     {31'd0, out_valid}, 32'd0);
        op("post_arst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
